video_timing_gen: RTL



---
 rtl/video_timing_gen.sv | 117 +++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with registered sync, blank, de and line/frame strobes
`timescale 1ns/1ps
module video_timing_gen #(
  parameter int HW       = 10,
  parameter int VW       = 9,
  parameter int H_ACTIVE = 320,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 24,
  parameter int V_ACTIVE = 240,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 14
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          ce_pix,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hs,
  output logic          vs,
  output logic          hb,
  output logic          vb,
  output logic          de,
  output logic          new_line,
  output logic          new_frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_HB_START = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VB_START = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Reject timing sets that do not fit the counters or have an empty porch/sync.
  generate
    if (H_TOTAL > 2**HW || V_TOTAL > 2**VW ||
        H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
      $error("video_timing_gen: illegal timing parameters");
    end
  endgenerate

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic          hs_q, hs_d, vs_q, vs_d, hb_q, hb_d, vb_q, vb_d, de_q, de_d;
  logic          new_line_q, new_line_d, new_frame_q, new_frame_d;
  logic          step, h_wrap, v_wrap;

  // Next counter values, then every decode taken from those next values so the
  // registered decodes line up with the registered counters (no skew).
  always_comb begin
    step     = enable & ce_pix;
    h_wrap   = (hcount_q == H_LAST);
    v_wrap   = (vcount_q == V_LAST);
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (step) begin
      if (h_wrap) begin
        hcount_d = '0;
        vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end
    hb_d        = (hcount_d >= H_HB_START);
    hs_d        = (hcount_d >= H_HS_START) && (hcount_d < H_HS_END);
    vb_d        = (vcount_d >= V_VB_START);
    vs_d        = (vcount_d >= V_VS_START) && (vcount_d < V_VS_END);
    de_d        = ~hb_d & ~vb_d;
    new_line_d  = step & h_wrap;
    new_frame_d = step & h_wrap & v_wrap;
  end

  // Single register stage for counters, levels and strobes; reset parks on the last pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q    <= H_LAST;
      vcount_q    <= V_LAST;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      hb_q        <= 1'b1;
      vb_q        <= 1'b1;
      de_q        <= 1'b0;
      new_line_q  <= 1'b0;
      new_frame_q <= 1'b0;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      hb_q        <= hb_d;
      vb_q        <= vb_d;
      de_q        <= de_d;
      new_line_q  <= new_line_d;
      new_frame_q <= new_frame_d;
    end
  end

  assign hcount    = hcount_q;
  assign vcount    = vcount_q;
  assign hs        = hs_q;
  assign vs        = vs_q;
  assign hb        = hb_q;
  assign vb        = vb_q;
  assign de        = de_q;
  assign new_line  = new_line_q;
  assign new_frame = new_frame_q;

endmodule
